// File: rtl/temporal_buffer_pkg.sv
// temporal_buffer_pkg: shared state encoding and default sizing for the temporal buffer sequencer and wrapper
package temporal_buffer_pkg;
  localparam int STATE_BITS = 3;
  localparam int DEF_NSAT = 3;
  localparam int DEF_NSAT_BITS = 2;
  typedef enum logic [STATE_BITS-1:0] {IDLE, FILL, WAIT_SEL, READ, OUT} state_t;
endpackage

// File: rtl/temporal_buffer_sequencer_if.sv
// temporal_buffer_sequencer_if: round control, candidate, selector, buffer-index and clause handshake signals; slave = sequencer, master = environment
interface temporal_buffer_sequencer_if #(parameter int NSAT_BITS = temporal_buffer_pkg::DEF_NSAT_BITS);
  logic start_i;
  logic [NSAT_BITS:0] num_cand_i;
  logic abort_i;
  logic cand_valid_i;
  logic cand_ready_o;
  logic sel_valid_i;
  logic [NSAT_BITS-1:0] sel_index_i;
  logic tb_write_en_o;
  logic [NSAT_BITS-1:0] tb_write_index_o;
  logic [NSAT_BITS-1:0] tb_read_index_o;
  logic clause_valid_o;
  logic clause_ready_i;
  logic busy_o;
  logic done_o;
  logic error_o;
  modport slave (
    input start_i, num_cand_i, abort_i, cand_valid_i, sel_valid_i, sel_index_i, clause_ready_i,
    output cand_ready_o, tb_write_en_o, tb_write_index_o, tb_read_index_o, clause_valid_o, busy_o, done_o, error_o
  );
  modport master (
    output start_i, num_cand_i, abort_i, cand_valid_i, sel_valid_i, sel_index_i, clause_ready_i,
    input cand_ready_o, tb_write_en_o, tb_write_index_o, tb_read_index_o, clause_valid_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/tb_seq_watchdog.sv
// tb_seq_watchdog: loadable up-counter (clk, reset, load in; tc out) flagging LIMIT cycles since the last load
module tb_seq_watchdog #(
  parameter int LIMIT = 1024,
  parameter int BITS = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tc
);
  logic [BITS-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || load) ? '0 : cnt + 1'b1;
  assign tc = cnt == BITS'(LIMIT - 1);
endmodule

// File: rtl/temporal_buffer_sequencer.sv
// temporal_buffer_sequencer: flip-round control FSM (ports clk, reset, bus slave modport); TB_SEQ_WATCHDOG_EN adds a WAIT_SEL timeout
module temporal_buffer_sequencer
  import temporal_buffer_pkg::*;
#(
  parameter int NSAT = DEF_NSAT,
  parameter int NSAT_BITS = DEF_NSAT_BITS,
  parameter int SEL_TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_BITS = 11
) (
  input logic clk,
  input logic reset,
  temporal_buffer_sequencer_if.slave bus
);
  state_t state;
  logic [NSAT_BITS:0] n;
  logic [NSAT_BITS-1:0] k, rd;
  logic ready, valid, busy, done, err;
  logic start_ok, last, sel_ok, timeout;
  if (2 ** TIMEOUT_BITS <= SEL_TIMEOUT_CYCLES) begin : g_bad_timeout_bits
    $error("TIMEOUT_BITS too narrow for SEL_TIMEOUT_CYCLES");
  end
  assign start_ok = bus.num_cand_i != '0 && bus.num_cand_i <= (NSAT_BITS+1)'(NSAT);
  assign last = {1'b0, k} == n - 1'b1;
  assign sel_ok = {1'b0, bus.sel_index_i} < n;
`ifdef TB_SEQ_WATCHDOG_EN
  tb_seq_watchdog #(.LIMIT(SEL_TIMEOUT_CYCLES), .BITS(TIMEOUT_BITS)) u_wd (
    .clk(clk),
    .reset(reset),
    .load(state != WAIT_SEL),
    .tc(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      k <= '0;
      rd <= '0;
      ready <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (bus.abort_i && state != IDLE) begin
        state <= IDLE;
        ready <= 1'b0;
        valid <= 1'b0;
        busy <= 1'b0;
        err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (bus.start_i) begin
            if (start_ok) begin
              n <= bus.num_cand_i;
              k <= '0;
              state <= FILL;
              ready <= 1'b1;
              busy <= 1'b1;
            end else err <= 1'b1;
          end
          FILL: if (bus.cand_valid_i) begin
            if (last) begin
              state <= WAIT_SEL;
              ready <= 1'b0;
            end else k <= k + 1'b1;
          end
          WAIT_SEL: if (bus.sel_valid_i && sel_ok) begin
            rd <= bus.sel_index_i;
            state <= READ;
          end else if (bus.sel_valid_i || timeout) begin
            state <= IDLE;
            busy <= 1'b0;
            err <= 1'b1;
          end
          READ: begin
            state <= OUT;
            valid <= 1'b1;
          end
          OUT: if (bus.clause_ready_i) begin
            state <= IDLE;
            valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.cand_ready_o = ready;
  assign bus.tb_write_en_o = bus.cand_valid_i & ready;
  assign bus.tb_write_index_o = k;
  assign bus.tb_read_index_o = rd;
  assign bus.clause_valid_o = valid;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.error_o = err;
endmodule

// File: tb/tb_temporal_buffer_sequencer.sv
// tb_temporal_buffer_sequencer: table-driven rounds with write/read-index scoreboards plus hand-written abort, reset and watchdog sequences
module tb_temporal_buffer_sequencer;
`ifdef TB_SEQ_WATCHDOG_EN
  localparam int TO_CYC = 8;
  localparam int TO_BITS = 4;
`else
  localparam int TO_CYC = 1024;
  localparam int TO_BITS = 11;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  temporal_buffer_sequencer_if #(.NSAT_BITS(2)) bus ();
  temporal_buffer_sequencer #(.NSAT(3), .NSAT_BITS(2), .SEL_TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    int n;
    int sel;
    bit gap;
    int delay;
    bit poke;
    bit start_err;
    bit sel_err;
  } vec_t;
  vec_t vt[8];
  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int wq[$];
  int rq[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] all_outs();
    return {bus.cand_ready_o, bus.tb_write_en_o, bus.tb_write_index_o, bus.tb_read_index_o,
            bus.clause_valid_o, bus.busy_o, bus.done_o, bus.error_o};
  endfunction
  always @(negedge clk) begin
    if (bus.tb_write_en_o) begin
      n_writes++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got index %0d expected no write", bus.tb_write_index_o);
      end else chk("write_index", bus.tb_write_index_o, wq.pop_front());
    end
    if (bus.clause_valid_o && bus.clause_ready_i) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_clause: got read index %0d expected no handshake", bus.tb_read_index_o);
      end else chk("read_index_at_handshake", bus.tb_read_index_o, rq.pop_front());
    end
  end
  task automatic run_round(input vec_t v);
    int w0;
    w0 = n_writes;
    bus.start_i = 1'b1;
    bus.num_cand_i = 3'(v.n);
    tick();
    bus.start_i = 1'b0;
    if (v.start_err) begin
      chk("start_err_error", bus.error_o, 1);
      chk("start_err_busy", bus.busy_o, 0);
      tick();
      chk("start_err_error_clear", bus.error_o, 0);
      chk("start_err_busy_after", bus.busy_o, 0);
      return;
    end
    chk("start_busy", bus.busy_o, 1);
    chk("start_cand_ready", bus.cand_ready_o, 1);
    chk("start_write_index", bus.tb_write_index_o, 0);
    for (int b = 0; b < v.n; b++) begin
      if (v.gap) begin
        bus.cand_valid_i = 1'b0;
        if (v.poke && b == 1) begin
          bus.start_i = 1'b1;
          bus.num_cand_i = 3'd1;
          bus.sel_valid_i = 1'b1;
          bus.sel_index_i = 2'd0;
        end
        tick();
        bus.start_i = 1'b0;
        bus.sel_valid_i = 1'b0;
        if (v.poke && b == 1) begin
          chk("poke_busy", bus.busy_o, 1);
          chk("poke_cand_ready", bus.cand_ready_o, 1);
          chk("poke_write_index", bus.tb_write_index_o, 1);
        end
      end
      bus.cand_valid_i = 1'b1;
      wq.push_back(b);
      tick();
    end
    bus.cand_valid_i = 1'b0;
    chk("fill_writes", n_writes - w0, v.n);
    chk("fill_cand_ready_low", bus.cand_ready_o, 0);
    chk("fill_last_index", bus.tb_write_index_o, v.n - 1);
    tick();
    bus.sel_valid_i = 1'b1;
    bus.sel_index_i = 2'(v.sel);
    if (!v.sel_err) rq.push_back(v.sel);
    tick();
    bus.sel_valid_i = 1'b0;
    if (v.sel_err) begin
      chk("sel_err_error", bus.error_o, 1);
      chk("sel_err_busy", bus.busy_o, 0);
      chk("sel_err_clause_valid", bus.clause_valid_o, 0);
      tick();
      chk("sel_err_error_clear", bus.error_o, 0);
      chk("sel_err_clause_valid_after", bus.clause_valid_o, 0);
      return;
    end
    chk("read_index", bus.tb_read_index_o, v.sel);
    chk("read_clause_valid_low", bus.clause_valid_o, 0);
    tick();
    chk("out_clause_valid", bus.clause_valid_o, 1);
    for (int i = 0; i < v.delay; i++) begin
      tick();
      chk("backpressure_clause_valid", bus.clause_valid_o, 1);
      chk("backpressure_no_done", bus.done_o, 0);
    end
    bus.clause_ready_i = 1'b1;
    tick();
    bus.clause_ready_i = 1'b0;
    chk("done_pulse", bus.done_o, 1);
    chk("done_clause_valid", bus.clause_valid_o, 0);
    chk("done_busy", bus.busy_o, 0);
    tick();
    chk("done_once", bus.done_o, 0);
  endtask
  initial begin
    int w0;
    int hit;
    bit stayed;
    vt[0] = '{3, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{3, 0, 1'b1, 5, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{4, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{2, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{3, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vt[7] = '{3, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    bus.start_i = 1'b0;
    bus.num_cand_i = '0;
    bus.abort_i = 1'b0;
    bus.cand_valid_i = 1'b0;
    bus.sel_valid_i = 1'b0;
    bus.sel_index_i = '0;
    bus.clause_ready_i = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    tick();
    chk("idle_outputs", all_outs(), 0);
    for (int i = 0; i < 8; i++) run_round(vt[i]);
    w0 = n_writes;
    bus.start_i = 1'b1;
    bus.num_cand_i = 3'd3;
    tick();
    bus.start_i = 1'b0;
    bus.cand_valid_i = 1'b1;
    wq.push_back(0);
    tick();
    bus.cand_valid_i = 1'b0;
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_error", bus.error_o, 1);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_cand_ready", bus.cand_ready_o, 0);
    bus.cand_valid_i = 1'b1;
    repeat (3) tick();
    bus.cand_valid_i = 1'b0;
    chk("abort_writes", n_writes - w0, 1);
    chk("abort_error_clear", bus.error_o, 0);
    bus.start_i = 1'b1;
    bus.num_cand_i = 3'd2;
    tick();
    bus.start_i = 1'b0;
    bus.cand_valid_i = 1'b1;
    wq.push_back(0);
    wq.push_back(1);
    tick();
    tick();
    bus.cand_valid_i = 1'b0;
    bus.sel_valid_i = 1'b1;
    bus.sel_index_i = 2'd1;
    tick();
    bus.sel_valid_i = 1'b0;
    tick();
    chk("pre_reset_clause_valid", bus.clause_valid_o, 1);
    chk("pre_reset_read_index", bus.tb_read_index_o, 1);
    reset = 1'b1;
    tick();
    chk("reset_in_out_outputs", all_outs(), 0);
    reset = 1'b0;
    tick();
    chk("after_reset_busy", bus.busy_o, 0);
    bus.start_i = 1'b1;
    bus.num_cand_i = 3'd1;
    tick();
    bus.start_i = 1'b0;
    bus.cand_valid_i = 1'b1;
    wq.push_back(0);
    tick();
    bus.cand_valid_i = 1'b0;
`ifdef TB_SEQ_WATCHDOG_EN
    hit = 0;
    for (int i = 1; i <= 20 && hit == 0; i++) begin
      tick();
      if (bus.error_o) hit = i;
    end
    chk("watchdog_latency", hit, 8);
    chk("watchdog_busy", bus.busy_o, 0);
`else
    stayed = 1'b1;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.busy_o || bus.clause_valid_o || bus.error_o) stayed = 1'b0;
    end
    chk("wait_sel_holds", stayed, 1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("wait_sel_abort_error", bus.error_o, 1);
    chk("wait_sel_abort_busy", bus.busy_o, 0);
`endif
    tick();
    chk("write_queue_empty", wq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
